// File: rtl/alu_mc_if.sv
// alu_mc_if: issue/result bundle between the control unit and alu_mc.
//   start, ctrl, op1, op2 : issue request, operation code and operands
//   busy, done            : iterative-op in progress / one-cycle completion pulse
//   out, zero, ovf, err   : registered result and its flags
interface alu_mc_if #(
    parameter int L_DATA = 16
);
    logic              start;
    logic [3:0]        ctrl;
    logic [L_DATA-1:0] op1;
    logic [L_DATA-1:0] op2;
    logic              busy;
    logic              done;
    logic [L_DATA-1:0] out;
    logic              zero;
    logic              ovf;
    logic              err;

    modport master (
        output start, ctrl, op1, op2,
        input  busy, done, out, zero, ovf, err
    );

    modport slave (
        input  start, ctrl, op1, op2,
        output busy, done, out, zero, ovf, err
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU. Single-cycle ops (add/sub/or/and/xor/slt/sltu)
// complete one edge after issue; shifts take shamt cycles (one bit per edge)
// and multiply takes L_DATA cycles of shift-add.
//   clock  : sole clock, rising edge
//   resetn : synchronous active-low reset, aborts any running operation
//   bus    : alu_mc_if slave modport (start/ctrl/op1/op2 in,
//            busy/done/out/zero/ovf/err out)
module alu_mc #(
    parameter int L_DATA = 16
) (
    input  logic     clock,
    input  logic     resetn,
    alu_mc_if.slave  bus
);
    localparam int SH_W = $clog2(L_DATA);
    localparam int CW   = SH_W + 1;
    localparam int MSB  = L_DATA - 1;
    localparam logic [CW-1:0] MUL_STEPS = CW'(L_DATA);
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_MUL  = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;

    typedef enum logic [0:0] {IDLE = 1'b0, EXEC = 1'b1} state_t;

    state_t              state_r, state_s;
    logic [3:0]          ctrl_r, ctrl_s;
    logic [CW-1:0]       cnt_r, cnt_s;
    logic [L_DATA-1:0]   a_r, a_s;          // shift register / multiplicand
    logic [2*L_DATA-1:0] prod_r, prod_s;    // {partial sum, multiplier}
    logic [L_DATA-1:0]   out_r, out_s;
    logic                zero_r, zero_s;
    logic                ovf_r, ovf_s;
    logic                err_r, err_s;
    logic                done_r, done_s;

    logic [L_DATA-1:0]   res1_s;
    logic                ovf1_s;
    logic                err1_s;
    logic                is_shift_s;
    logic [SH_W-1:0]     shamt_s;
    logic [L_DATA-1:0]   sh_next_s;
    logic [L_DATA:0]     sum_s;
    logic [2*L_DATA-1:0] prod_next_s;

    assign is_shift_s = (bus.ctrl == OP_SHR) || (bus.ctrl == OP_SHL) || (bus.ctrl == OP_SRA);
    assign shamt_s    = bus.op2[SH_W-1:0];

    // Single-cycle result from the live operands (used only on the accept edge).
    // A shift by zero simply passes op1 through.
    always_comb begin
        res1_s = {L_DATA{1'b0}};
        ovf1_s = 1'b0;
        err1_s = 1'b0;
        case (bus.ctrl)
            OP_ADD: begin
                res1_s = bus.op1 + bus.op2;
                ovf1_s = (bus.op1[MSB] == bus.op2[MSB]) && (res1_s[MSB] != bus.op1[MSB]);
            end
            OP_SUB: begin
                res1_s = bus.op1 - bus.op2;
                ovf1_s = (bus.op1[MSB] != bus.op2[MSB]) && (res1_s[MSB] != bus.op1[MSB]);
            end
            OP_OR:   res1_s = bus.op1 | bus.op2;
            OP_AND:  res1_s = bus.op1 & bus.op2;
            OP_XOR:  res1_s = bus.op1 ^ bus.op2;
            OP_SLT:  res1_s = {{(L_DATA-1){1'b0}}, ($signed(bus.op1) < $signed(bus.op2))};
            OP_SLTU: res1_s = {{(L_DATA-1){1'b0}}, (bus.op1 < bus.op2)};
            OP_SHR, OP_SHL, OP_SRA: res1_s = bus.op1;
            OP_MUL:  res1_s = {L_DATA{1'b0}};
            default: begin
                res1_s = {L_DATA{1'b0}};
                err1_s = 1'b1;
            end
        endcase
    end

    // One iteration step: single-bit shift of a_r, and one shift-add multiply step.
    always_comb begin
        case (ctrl_r)
            OP_SHR:  sh_next_s = {1'b0, a_r[MSB:1]};
            OP_SHL:  sh_next_s = {a_r[MSB-1:0], 1'b0};
            OP_SRA:  sh_next_s = {a_r[MSB], a_r[MSB:1]};
            default: sh_next_s = a_r;
        endcase
        if (prod_r[0]) begin
            sum_s = {1'b0, prod_r[2*L_DATA-1:L_DATA]} + {1'b0, a_r};
        end else begin
            sum_s = {1'b0, prod_r[2*L_DATA-1:L_DATA]};
        end
        prod_next_s = {sum_s, prod_r[L_DATA-1:1]};
    end

    // Next-state and result logic for the IDLE/EXEC controller.
    always_comb begin
        state_s = state_r;
        ctrl_s  = ctrl_r;
        cnt_s   = cnt_r;
        a_s     = a_r;
        prod_s  = prod_r;
        out_s   = out_r;
        zero_s  = zero_r;
        ovf_s   = ovf_r;
        err_s   = err_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    ctrl_s = bus.ctrl;
                    a_s    = bus.op1;
                    prod_s = {{L_DATA{1'b0}}, bus.op2};
                    if (is_shift_s && (shamt_s != {SH_W{1'b0}})) begin
                        cnt_s   = {1'b0, shamt_s};
                        state_s = EXEC;
                    end else if (bus.ctrl == OP_MUL) begin
                        cnt_s   = MUL_STEPS;
                        state_s = EXEC;
                    end else begin
                        out_s  = res1_s;
                        zero_s = (res1_s == {L_DATA{1'b0}});
                        ovf_s  = ovf1_s;
                        err_s  = err1_s;
                        done_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                a_s    = sh_next_s;
                prod_s = prod_next_s;
                cnt_s  = cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    if (ctrl_r == OP_MUL) begin
                        out_s = prod_next_s[L_DATA-1:0];
                        ovf_s = (prod_next_s[2*L_DATA-1:L_DATA] != {L_DATA{1'b0}});
                    end else begin
                        out_s = sh_next_s;
                        ovf_s = 1'b0;
                    end
                    zero_s  = (out_s == {L_DATA{1'b0}});
                    err_s   = 1'b0;
                    done_s  = 1'b1;
                    state_s = IDLE;
                end else begin
                    state_s = EXEC;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r <= IDLE;
            ctrl_r  <= 4'd0;
            cnt_r   <= {CW{1'b0}};
            a_r     <= {L_DATA{1'b0}};
            prod_r  <= {(2*L_DATA){1'b0}};
            out_r   <= {L_DATA{1'b0}};
            zero_r  <= 1'b1;
            ovf_r   <= 1'b0;
            err_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ctrl_r  <= ctrl_s;
            cnt_r   <= cnt_s;
            a_r     <= a_s;
            prod_r  <= prod_s;
            out_r   <= out_s;
            zero_r  <= zero_s;
            ovf_r   <= ovf_s;
            err_r   <= err_s;
            done_r  <= done_s;
        end
    end

    assign bus.busy = (state_r == EXEC);
    assign bus.done = done_r;
    assign bus.out  = out_r;
    assign bus.zero = zero_r;
    assign bus.ovf  = ovf_r;
    assign bus.err  = err_r;
endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
    logic clock;
    logic resetn;
    int   total;
    int   bad;
    int   lat;
    int   bcnt;
    int   seen;

    alu_mc_if #(.L_DATA(16)) bus ();

    alu_mc #(.L_DATA(16)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op at a negedge and wait (bounded) for done; returns latency and busy count.
    task automatic run_op(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                          output int l, output int bc);
        @(negedge clock);
        bus.start = 1'b1;
        bus.ctrl  = c;
        bus.op1   = a;
        bus.op2   = b;
        l  = 0;
        bc = 0;
        do begin
            @(negedge clock);
            bus.start = 1'b0;
            l++;
            if (bus.busy) bc++;
        end while (!bus.done && l < 100);
        if (!bus.done) check("timeout", {31'd0, bus.done}, 32'd1);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        resetn    = 1'b0;
        bus.start = 1'b0;
        bus.ctrl  = 4'd0;
        bus.op1   = 16'h0000;
        bus.op2   = 16'h0000;
        repeat (3) @(negedge clock);
        check("rst_out",  {16'd0, bus.out}, 32'h0);
        check("rst_zero", {31'd0, bus.zero}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_ovf",  {31'd0, bus.ovf}, 32'd0);
        check("rst_err",  {31'd0, bus.err}, 32'd0);
        resetn = 1'b1;

        // ADD with signed overflow
        run_op(4'd0, 16'h7FFF, 16'h0001, lat, bcnt);
        check("add_lat",  lat, 32'd1);
        check("add_busy", bcnt, 32'd0);
        check("add_out",  {16'd0, bus.out}, 32'h8000);
        check("add_ovf",  {31'd0, bus.ovf}, 32'd1);
        check("add_zero", {31'd0, bus.zero}, 32'd0);

        // SUB to zero
        run_op(4'd1, 16'h0005, 16'h0005, lat, bcnt);
        check("sub_out",  {16'd0, bus.out}, 32'h0);
        check("sub_zero", {31'd0, bus.zero}, 32'd1);
        check("sub_ovf",  {31'd0, bus.ovf}, 32'd0);

        // signed vs unsigned compare
        run_op(4'd6, 16'hFFFF, 16'h0001, lat, bcnt);
        check("slt_out", {16'd0, bus.out}, 32'h1);
        run_op(4'd10, 16'hFFFF, 16'h0001, lat, bcnt);
        check("sltu_out", {16'd0, bus.out}, 32'h0);

        // logic ops
        run_op(4'd8, 16'hF0F0, 16'hFF00, lat, bcnt);
        check("xor_out", {16'd0, bus.out}, 32'h0FF0);
        run_op(4'd3, 16'hF0F0, 16'hFF00, lat, bcnt);
        check("and_out", {16'd0, bus.out}, 32'hF000);

        // MUL 300*300 = 0x15F90
        run_op(4'd7, 16'd300, 16'd300, lat, bcnt);
        check("mul_lat",  lat, 32'd17);
        check("mul_busy", bcnt, 32'd16);
        check("mul_out",  {16'd0, bus.out}, 32'h5F90);
        check("mul_ovf",  {31'd0, bus.ovf}, 32'd1);
        run_op(4'd7, 16'd7, 16'd9, lat, bcnt);
        check("mul7x9_out", {16'd0, bus.out}, 32'h003F);
        check("mul7x9_ovf", {31'd0, bus.ovf}, 32'd0);

        // shifts
        run_op(4'd5, 16'h0001, 16'd15, lat, bcnt);
        check("shl_out",  {16'd0, bus.out}, 32'h8000);
        check("shl_busy", bcnt, 32'd15);
        check("shl_lat",  lat, 32'd16);
        run_op(4'd9, 16'h8000, 16'd3, lat, bcnt);
        check("sra_out", {16'd0, bus.out}, 32'hF000);
        run_op(4'd4, 16'h8000, 16'd3, lat, bcnt);
        check("shr_out", {16'd0, bus.out}, 32'h1000);
        run_op(4'd4, 16'h1234, 16'd0, lat, bcnt);
        check("shr0_out",  {16'd0, bus.out}, 32'h1234);
        check("shr0_lat",  lat, 32'd1);
        check("shr0_busy", bcnt, 32'd0);

        // start during MUL is ignored
        @(negedge clock);
        bus.start = 1'b1;
        bus.ctrl  = 4'd7;
        bus.op1   = 16'd300;
        bus.op2   = 16'd300;
        @(negedge clock);
        bus.start = 1'b0;
        lat = 1;
        repeat (3) begin
            @(negedge clock);
            lat++;
        end
        bus.start = 1'b1;
        bus.ctrl  = 4'd0;
        bus.op1   = 16'd1;
        bus.op2   = 16'd1;
        @(negedge clock);
        bus.start = 1'b0;
        lat++;
        while (!bus.done && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        check("ign_lat", lat, 32'd17);
        check("ign_out", {16'd0, bus.out}, 32'h5F90);
        seen = 0;
        repeat (5) begin
            @(negedge clock);
            if (bus.done) seen++;
        end
        check("ign_noqueue", seen, 32'd0);
        check("ign_hold", {16'd0, bus.out}, 32'h5F90);

        // start in the done cycle is accepted
        run_op(4'd7, 16'd7, 16'd9, lat, bcnt);
        bus.start = 1'b1;
        bus.ctrl  = 4'd0;
        bus.op1   = 16'h0010;
        bus.op2   = 16'h0020;
        @(negedge clock);
        bus.start = 1'b0;
        check("b2b_done", {31'd0, bus.done}, 32'd1);
        check("b2b_out",  {16'd0, bus.out}, 32'h0030);

        // reserved code, then ADD clears err
        run_op(4'd12, 16'h1111, 16'h2222, lat, bcnt);
        check("rsv_out", {16'd0, bus.out}, 32'h0);
        check("rsv_err", {31'd0, bus.err}, 32'd1);
        check("rsv_lat", lat, 32'd1);
        run_op(4'd0, 16'h0001, 16'h0001, lat, bcnt);
        check("clr_err", {31'd0, bus.err}, 32'd0);
        check("clr_out", {16'd0, bus.out}, 32'h0002);

        // reset at the 5th busy cycle of a MUL
        @(negedge clock);
        bus.start = 1'b1;
        bus.ctrl  = 4'd7;
        bus.op1   = 16'd300;
        bus.op2   = 16'd300;
        bcnt = 0;
        for (int i = 0; i < 40 && bcnt < 5; i++) begin
            @(negedge clock);
            bus.start = 1'b0;
            if (bus.busy) bcnt++;
        end
        check("mrst_reach", bcnt, 32'd5);
        resetn = 1'b0;
        @(negedge clock);
        check("mrst_busy", {31'd0, bus.busy}, 32'd0);
        check("mrst_out",  {16'd0, bus.out}, 32'h0);
        check("mrst_zero", {31'd0, bus.zero}, 32'd1);
        resetn = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clock);
            if (bus.done) seen++;
        end
        check("mrst_nodone", seen, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
